// File: rtl/pes_piso.sv
`default_nettype none
// ============================================================================
//  Module   : pes_piso
//  Purpose  : Parallel-in / serial-out shifter with a one-word holding buffer.
//             Words are sent LSB first, advanced by shift_en, and the next
//             buffered word follows the current one with no idle gap.
//  Revision : 1.0  initial release
// ============================================================================
module pes_piso #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic             shift_en,
   output logic             serial_out,
   output logic             serial_valid,
   output logic             frame_start,
   output logic             done
);

   localparam int                CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SHIFT = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [WIDTH-1:0]   sr_q, sr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]   hold_q, hold_d;
   logic               hold_full_q, hold_full_d;
   logic               done_q, done_d;
   logic               accept;

   // Buffer is free only when empty; forced busy during reset so nothing lands.
   assign load_ready = ~hold_full_q & ~reset;
   assign accept     = load_valid & load_ready;

   // State register; reset discards the word in flight and any buffered word.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         sr_q        <= '0;
         cnt_q       <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         cnt_q       <= cnt_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         done_q      <= done_d;
      end
   end

   // Next state: buffer-to-shifter transfer, bit advance, and word completion.
   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      cnt_d       = cnt_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      done_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (hold_full_q) begin
               sr_d        = hold_q;
               cnt_d       = '0;
               hold_full_d = 1'b0;
               state_d     = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (shift_en) begin
               if (cnt_q == CNT_LAST) begin
                  done_d = 1'b1;
                  if (hold_full_q) begin
                     // Chain straight into the buffered word.
                     sr_d        = hold_q;
                     cnt_d       = '0;
                     hold_full_d = 1'b0;
                  end else begin
                     state_d = S_IDLE;
                  end
               end else begin
                  sr_d  = sr_q >> 1;
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      // An accept only happens with the buffer empty, so it can never collide
      // with a transfer out of the buffer above.
      if (accept) begin
         hold_d      = data_in;
         hold_full_d = 1'b1;
      end
   end

   // Serial outputs are only meaningful while shifting; forced low when idle.
   always_comb begin
      serial_valid = (state_q == S_SHIFT);
      serial_out   = (state_q == S_SHIFT) & sr_q[0];
      frame_start  = (state_q == S_SHIFT) & (cnt_q == '0);
      done         = done_q;
   end

endmodule
`default_nettype wire
